hazard_scoreboard_ctrl: RTL and testbench
=========================================

Name: hazard_scoreboard_ctrl

Overview:
- Pipeline interlock controller for the 5-stage core. It sits beside the decode stage and drives that stage's `Hazard` input.
- It keeps a 3-entry shift scoreboard holding destination, write-enable and load flag for the instructions now in EXE, MEM and WB.
- It compares the decode-stage source registers against the scoreboard and raises a stall when a read-after-write conflict cannot be resolved.
- It keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- `CNT_W`, 16: width of the stall-cycle counter.
- `REG_W`, 4: register index width (16 architectural registers).

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-low; acts on the rising edge of `clk` while low.
- `id_src1`  in  REG_W  Rn index of the decode-stage instruction.
- `id_src2`  in  REG_W  second source index (Rm, or Rd for stores).
- `id_two_src`  in  1  decode instruction reads `id_src2`.
- `id_wb_en`  in  1  decode instruction writes `id_dest` (pre-bubble control).
- `id_mem_r_en`  in  1  decode instruction is a load.
- `id_dest`  in  REG_W  destination index of the decode instruction.
- `flush`  in  1  taken branch resolved in EXE; decode-stage instruction is squashed.
- `freeze`  in  1  memory stall; the whole pipeline holds.
- `hazard`  out  1  to the decode stage: insert a bubble and hold IF/ID.
- `fwd_sel1`  out  2  EXE operand-1 select (forwarding build only, else 0).
- `fwd_sel2`  out  2  EXE operand-2 select (forwarding build only, else 0).
- `stall_cnt`  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Scoreboard slots E (EXE), M (MEM) and W (WB). Each slot holds {valid, wb_en, mem_r_en, dest, src1, src2, two_src}.
- Reset (`rst`=0 at a rising edge): all slots invalid with zero fields; `stall_cnt`=0. Outputs then read `hazard`=0, `fwd_sel1`=0, `fwd_sel2`=0.
- Match rule: a source matches slot X when `X.valid & X.wb_en & (src == X.dest)`.
  - r15 is never matched; r15 reads return PC.
  - `id_src2` is checked only when `id_two_src`=1.
- `hazard` is combinational, zero latency, from the decode inputs and slots E and M.
  - Without forwarding: `hazard` = match(`id_src1`, E or M) | match(`id_src2`, E or M).
  - Slot W never stalls: the register file writes on negedge, so the value is readable the same cycle.
- `hazard` is forced to 0 while `flush`=1, because the decode instruction is discarded anyway.
- Update on each rising edge with `rst`=1:
  - If `freeze`=1: all slots hold and `stall_cnt` holds.
  - Otherwise M moves to W, and E moves to M.
  - E loads the decode instruction's fields with valid = ~`hazard` & ~`flush`. A bubble loads valid=0.
- `stall_cnt` increments when `hazard`=1 & `freeze`=0. It saturates at all-ones and does not wrap.
- Simultaneous `freeze` and `flush`: `freeze` wins and nothing moves. `flush` is re-sampled on the next unfrozen cycle.
- `rst` asserted mid-stall clears all slots. `hazard` drops in the same cycle the slots clear.
- A back-to-back dependent chain stalls at most 2 cycles without forwarding.

Optional Feature:
- Macro `HAZARD_FORWARDING_EN`.
- Defined:
  - `hazard` = `E.mem_r_en` & match(decode src, E) only, i.e. load-use only: 1 stall cycle.
  - `fwd_sel1` and `fwd_sel2` are computed from slot E's stored sources:
    - 2'b01 if the source matches M (ALU result in MEM).
    - else 2'b10 if it matches W (WB value).
    - else 2'b00.
  - M has priority over W. The `fwd_sel2` check honours `E.two_src`.
- Undefined: `fwd_sel1` and `fwd_sel2` are tied to 0, and the full E/M stall rule above applies.

Test Plan:
- Reset: hold `rst`=0 for 2 clocks → `hazard`=0, `stall_cnt`=0 and all slots invalid. Then issue ADD r1 and SUB using r1 → `hazard`=1 for 2 cycles, then 0; `stall_cnt`=2.
- Independent stream: ADD r1,r2,r3 then ADD r4,r5,r6 → `hazard` stays 0 and `stall_cnt` stays 0.
- r15 source after a write to r15, plus a store (`id_two_src`=1) whose Rd matches E.dest → no stall for r15; 2-cycle stall for the store.
- Freeze: dependent pair with `freeze`=1 for 3 cycles mid-stall → slots hold, `stall_cnt` unchanged during freeze, and the stall completes after release. Flush with a dependent decode → `hazard`=0 and E loads a bubble.
- Saturation: force 2^CNT_W+3 stall cycles → `stall_cnt`=0xFFFF and holds.
- Forwarding build:
  - LDR r2 then ADD r3,r2,r2 → exactly 1 stall; `fwd_sel1`=`fwd_sel2`=2'b10 when the ADD reaches EXE.
  - ADD r2 then SUB using r2 → no stall; `fwd_sel1`=2'b01.

Source files
------------

// File: rtl/hazard_scoreboard_ctrl.sv
// rtl/hazard_scoreboard_ctrl.sv - decode-stage RAW interlock with EXE/MEM/WB shift scoreboard
// Optional HAZARD_FORWARDING_EN: load-use-only stall plus EXE operand forwarding selects.
module hazard_scoreboard_ctrl #(
    parameter int CNT_W = 16,
    parameter int REG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic [REG_W-1:0] id_dest,
    input  logic             flush,
    input  logic             freeze,
    output logic             hazard,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic             mem_r_en;
        logic [REG_W-1:0] dest;
        logic [REG_W-1:0] src1;
        logic [REG_W-1:0] src2;
        logic             two_src;
    } slot_t;

    // r15 reads return the PC, so it can never carry a register dependency
    localparam logic [REG_W-1:0] PC_REG = '1;

    slot_t            e_q, m_q, w_q, e_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             raw_hazard;

    function automatic logic match(input logic [REG_W-1:0] src, input slot_t s);
        return s.valid & s.wb_en & (src == s.dest) & (src != PC_REG);
    endfunction

`ifdef HAZARD_FORWARDING_EN
    logic unused_fields;
    assign unused_fields = ^{w_q.mem_r_en, w_q.src1, w_q.src2, w_q.two_src};

    always_comb begin
        raw_hazard = e_q.mem_r_en &
                     (match(id_src1, e_q) | (id_two_src & match(id_src2, e_q)));
    end

    // MEM holds the youngest result, so it takes priority over WB
    always_comb begin
        fwd_sel1 = 2'b00;
        fwd_sel2 = 2'b00;
        if (match(e_q.src1, m_q)) begin
            fwd_sel1 = 2'b01;
        end else if (match(e_q.src1, w_q)) begin
            fwd_sel1 = 2'b10;
        end
        if (e_q.two_src) begin
            if (match(e_q.src2, m_q)) begin
                fwd_sel2 = 2'b01;
            end else if (match(e_q.src2, w_q)) begin
                fwd_sel2 = 2'b10;
            end
        end
    end
`else
    logic unused_fields;
    assign unused_fields = ^w_q;

    // WB never stalls: the register file writes on the falling edge
    always_comb begin
        raw_hazard = match(id_src1, e_q) | match(id_src1, m_q) |
                     (id_two_src & (match(id_src2, e_q) | match(id_src2, m_q)));
    end

    assign fwd_sel1 = 2'b00;
    assign fwd_sel2 = 2'b00;
`endif

    assign hazard    = raw_hazard & ~flush;
    assign stall_cnt = cnt_q;

    always_comb begin
        e_d          = '0;
        e_d.valid    = ~hazard & ~flush;
        e_d.wb_en    = id_wb_en;
        e_d.mem_r_en = id_mem_r_en;
        e_d.dest     = id_dest;
        e_d.src1     = id_src1;
        e_d.src2     = id_src2;
        e_d.two_src  = id_two_src;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hazard && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else if (!freeze) begin
            w_q   <= m_q;
            m_q   <= e_q;
            e_q   <= e_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// tb/tb_hazard_scoreboard_ctrl.sv - self-checking bench for hazard_scoreboard_ctrl
module tb_hazard_scoreboard_ctrl;
    // reduced counter width keeps the saturation run short
    localparam int CNT_W   = 12;
    localparam int REG_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [REG_W-1:0] id_src1, id_src2, id_dest;
    logic             id_two_src, id_wb_en, id_mem_r_en;
    logic             flush, freeze;
    logic             hazard;
    logic [1:0]       fwd_sel1, fwd_sel2;
    logic [CNT_W-1:0] stall_cnt;

    hazard_scoreboard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
        .flush(flush), .freeze(freeze),
        .hazard(hazard), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        bit wb;
        bit ld;
        int dest;
        int s1;
        int s2;
        bit two;
    } ins_t;

    ins_t pipe[3];  // 0 = EXE, 1 = MEM, 2 = WB
    int   m_cnt  = 0;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    function automatic bit writes(input ins_t p, input int r);
        return p.valid && p.wb && (p.dest == r) && (r != 15);
    endfunction

    function automatic bit model_hazard();
        int srcs[$];
        bit h = 1'b0;
        if (flush) return 1'b0;
        srcs.push_back(int'(id_src1));
        if (id_two_src) srcs.push_back(int'(id_src2));
        foreach (srcs[i]) begin
            if (FWD) begin
                if (pipe[0].ld && writes(pipe[0], srcs[i])) h = 1'b1;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    if (writes(pipe[d], srcs[i])) h = 1'b1;
                end
            end
        end
        return h;
    endfunction

    function automatic logic [1:0] model_fwd(input int src, input bit used);
        if (!FWD || !used) return 2'b00;
        if (writes(pipe[1], src)) return 2'b01;
        if (writes(pipe[2], src)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{default: 0};
            m_cnt = 0;
        end else if (!freeze) begin
            ins_t nxt;
            bit   h;
            h         = model_hazard();
            nxt.valid = !h && !flush;
            nxt.wb    = id_wb_en;
            nxt.ld    = id_mem_r_en;
            nxt.dest  = int'(id_dest);
            nxt.s1    = int'(id_src1);
            nxt.s2    = int'(id_src2);
            nxt.two   = id_two_src;
            if (h && m_cnt < CNT_MAX) m_cnt++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nxt;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_hazard", hazard, model_hazard());
            check("model_fwd1", fwd_sel1, model_fwd(pipe[0].s1, 1'b1));
            check("model_fwd2", fwd_sel2, model_fwd(pipe[0].s2, pipe[0].two));
            check("model_cnt", stall_cnt, m_cnt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input int s1, input int s2, input bit two, input bit wb,
                           input bit ld, input int dest);
        id_src1     = REG_W'(s1);
        id_src2     = REG_W'(s2);
        id_two_src  = two;
        id_wb_en    = wb;
        id_mem_r_en = ld;
        id_dest     = REG_W'(dest);
    endtask

    task automatic nop();
        set_dec(15, 15, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic sample_hz(input string name, input bit exp);
        @(negedge clk);
        check(name, hazard, exp);
        cyc();
    endtask

    task automatic peek_cnt(input string name, input int exp);
        @(negedge clk);
        check(name, stall_cnt, exp);
        cyc();
    endtask

    task automatic rst_pulse();
        nop();
        rst = 1'b0;
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        rst    = 1'b0;
        flush  = 1'b0;
        freeze = 1'b0;
        nop();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_hazard", hazard, 1'b0);
        check("reset_cnt", stall_cnt, 0);
        check("reset_fwd1", fwd_sel1, 2'b00);
        check("reset_fwd2", fwd_sel2, 2'b00);
        cyc();
        rst = 1'b1;

`ifndef HAZARD_FORWARDING_EN
        // ADD r1,r2,r3 then SUB r4,r1,r5: two stall cycles
        set_dec(2, 3, 1'b1, 1'b1, 1'b0, 1);
        sample_hz("t1_add", 1'b0);
        set_dec(1, 5, 1'b1, 1'b1, 1'b0, 4);
        sample_hz("t1_stall0", 1'b1);
        sample_hz("t1_stall1", 1'b1);
        sample_hz("t1_release", 1'b0);
        nop();
        peek_cnt("t1_cnt", 2);
        repeat (3) cyc();

        // independent stream
        rst_pulse();
        set_dec(2, 3, 1'b1, 1'b1, 1'b0, 1);
        sample_hz("t2_add1", 1'b0);
        set_dec(5, 6, 1'b1, 1'b1, 1'b0, 4);
        sample_hz("t2_add2", 1'b0);
        nop();
        peek_cnt("t2_cnt", 0);

        // r15 never matches; store Rd dependency stalls twice
        rst_pulse();
        set_dec(15, 15, 1'b0, 1'b1, 1'b0, 15);
        sample_hz("t3_mov_pc", 1'b0);
        set_dec(15, 2, 1'b1, 1'b0, 1'b0, 8);
        sample_hz("t3_r15_read", 1'b0);
        set_dec(3, 3, 1'b1, 1'b1, 1'b0, 7);
        sample_hz("t3_add_r7", 1'b0);
        set_dec(2, 7, 1'b1, 1'b0, 1'b0, 0);
        sample_hz("t3_str_s0", 1'b1);
        sample_hz("t3_str_s1", 1'b1);
        sample_hz("t3_str_rel", 1'b0);
        nop();
        peek_cnt("t3_cnt", 2);

        // freeze mid-stall
        rst_pulse();
        set_dec(2, 3, 1'b1, 1'b1, 1'b0, 1);
        sample_hz("t4_add", 1'b0);
        set_dec(1, 5, 1'b1, 1'b1, 1'b0, 4);
        sample_hz("t4_s0", 1'b1);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_frz_hz", hazard, 1'b1);
            check("t4_frz_cnt", stall_cnt, 1);
            cyc();
        end
        freeze = 1'b0;
        sample_hz("t4_s1", 1'b1);
        sample_hz("t4_rel", 1'b0);
        nop();
        peek_cnt("t4_cnt", 2);

        // flush squashes a dependent decode into a bubble
        rst_pulse();
        set_dec(2, 3, 1'b1, 1'b1, 1'b0, 1);
        sample_hz("t4_fl_add", 1'b0);
        set_dec(1, 5, 1'b1, 1'b1, 1'b0, 9);
        flush = 1'b1;
        sample_hz("t4_flush", 1'b0);
        flush = 1'b0;
        set_dec(9, 15, 1'b0, 1'b0, 1'b0, 0);
        sample_hz("t4_bubble", 1'b0);
        nop();
        repeat (3) cyc();

        // freeze beats flush: nothing moves
        rst_pulse();
        set_dec(2, 3, 1'b1, 1'b1, 1'b0, 1);
        sample_hz("t4_ff_add", 1'b0);
        set_dec(1, 5, 1'b1, 1'b1, 1'b0, 4);
        freeze = 1'b1;
        flush  = 1'b1;
        sample_hz("t4_ff", 1'b0);
        freeze = 1'b0;
        flush  = 1'b0;
        sample_hz("t4_ff_s0", 1'b1);
        sample_hz("t4_ff_s1", 1'b1);
        sample_hz("t4_ff_rel", 1'b0);
        nop();
        repeat (3) cyc();

        // reset during a stall
        rst_pulse();
        set_dec(2, 3, 1'b1, 1'b1, 1'b0, 1);
        sample_hz("t5_add", 1'b0);
        set_dec(1, 5, 1'b1, 1'b1, 1'b0, 4);
        sample_hz("t5_stall", 1'b1);
        rst = 1'b0;
        cyc();
        @(negedge clk);
        check("t5_rst_hz", hazard, 1'b0);
        check("t5_rst_cnt", stall_cnt, 0);
        cyc();
        rst = 1'b1;

        // saturation with a self-dependent chain
        rst_pulse();
        set_dec(1, 15, 1'b0, 1'b1, 1'b0, 1);
        repeat (6300) cyc();
        peek_cnt("t6_sat", CNT_MAX);
        repeat (10) cyc();
        peek_cnt("t6_sat_hold", CNT_MAX);
        nop();
        repeat (3) cyc();
`else
        // LDR r2 then ADD r3,r2,r2: one load-use stall, WB forwarding
        rst_pulse();
        set_dec(15, 15, 1'b0, 1'b1, 1'b1, 2);
        sample_hz("f_ldr", 1'b0);
        set_dec(2, 2, 1'b1, 1'b1, 1'b0, 3);
        sample_hz("f_ld_use", 1'b1);
        sample_hz("f_ld_rel", 1'b0);
        nop();
        @(negedge clk);
        check("f_ld_fwd1", fwd_sel1, 2'b10);
        check("f_ld_fwd2", fwd_sel2, 2'b10);
        check("f_ld_cnt", stall_cnt, 1);
        cyc();

        // ADD r2 then SUB r5,r2,r6: no stall, MEM forwarding
        rst_pulse();
        set_dec(3, 4, 1'b1, 1'b1, 1'b0, 2);
        sample_hz("f_add", 1'b0);
        set_dec(2, 6, 1'b1, 1'b1, 1'b0, 5);
        sample_hz("f_alu", 1'b0);
        nop();
        @(negedge clk);
        check("f_alu_fwd1", fwd_sel1, 2'b01);
        check("f_alu_fwd2", fwd_sel2, 2'b00);
        check("f_alu_cnt", stall_cnt, 0);
        cyc();
`endif

        repeat (2) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
